// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the packet requesters and the UART transmit stream.
// The arbiter uses the slave view; sources and the transmitter model use the master view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_ready;
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;
    logic                      timeout_pulse;

    modport slave (
        input  req_valid, req_last, req_data, out_ready,
        output req_ready, out_valid, out_data, grant_valid, grant_id, timeout_pulse
    );

    modport master (
        output req_valid, req_last, req_data, out_ready,
        input  req_ready, out_valid, out_data, grant_valid, grant_id, timeout_pulse
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one UART TX byte stream with idle-timeout revocation.
// Optional UART_ARB_TAG_EN: a tag byte 8'h80|grant_id precedes every granted packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_FIRE  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        TAG
    } state_t;

`ifdef UART_ARB_TAG_EN
    localparam state_t GRANT_STATE = TAG;
    localparam logic [DATA_W-1:0] TAG_BASE = DATA_W'(8'h80);
`else
    localparam state_t GRANT_STATE = PASS;
`endif

    state_t           state_reg;
    logic [ID_W-1:0]  ptr_reg;
    logic [ID_W-1:0]  grant_reg;
    logic [CNT_W-1:0] idle_cnt_reg;

    // Candidate order for the scan: ptr, ptr+1, ... wrapped without relying on power-of-two
    logic [ID_W-1:0] cand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [ID_W:0] sum;
            assign sum      = {1'b0, ptr_reg} + (ID_W + 1)'(gi);
            assign cand[gi] = (sum >= NUM_REQ_W) ? ID_W'(sum - NUM_REQ_W) : sum[ID_W-1:0];
        end
    endgenerate

    logic            sel_valid;
    logic [ID_W-1:0] sel_id;

    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[cand[k]]) begin
                sel_valid = 1'b1;
                sel_id    = cand[k];
            end
        end
    end

    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic [ID_W-1:0]   next_id;
    logic              xfer;
    logic              fire;

    assign g_valid = bus.req_valid[grant_reg];
    assign g_last  = bus.req_last[grant_reg];
    assign g_data  = bus.req_data[int'(grant_reg) * DATA_W +: DATA_W];
    assign next_id = (grant_reg == LAST_ID) ? '0 : grant_reg + 1'b1;
    assign xfer    = (state_reg == PASS) && g_valid && bus.out_ready;
    assign fire    = (state_reg == PASS) && !g_valid && (idle_cnt_reg == CNT_FIRE);

    // Outputs are forced to zero while reset is asserted so nothing transfers in that cycle
    always_comb begin
        bus.req_ready     = '0;
        bus.out_valid     = 1'b0;
        bus.out_data      = '0;
        bus.grant_valid   = 1'b0;
        bus.grant_id      = '0;
        bus.timeout_pulse = 1'b0;
        if (!reset) begin
            bus.grant_id = grant_reg;
            case (state_reg)
                PASS: begin
                    bus.req_ready[grant_reg] = bus.out_ready;
                    bus.out_valid            = g_valid;
                    bus.out_data             = g_data;
                    bus.grant_valid          = 1'b1;
                    bus.timeout_pulse        = fire;
                end
`ifdef UART_ARB_TAG_EN
                TAG: begin
                    bus.out_valid   = 1'b1;
                    bus.out_data    = TAG_BASE | DATA_W'(grant_reg);
                    bus.grant_valid = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            grant_reg    <= '0;
            idle_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sel_valid) begin
                        grant_reg    <= sel_id;
                        idle_cnt_reg <= '0;
                        state_reg    <= GRANT_STATE;
                    end
                end
`ifdef UART_ARB_TAG_EN
                TAG: begin
                    if (bus.out_ready) begin
                        idle_cnt_reg <= '0;
                        state_reg    <= PASS;
                    end
                end
`endif
                PASS: begin
                    if ((xfer && g_last) || fire) begin
                        state_reg    <= IDLE;
                        ptr_reg      <= next_id;
                        idle_cnt_reg <= '0;
                    end else if (g_valid) begin
                        idle_cnt_reg <= '0;
                    end else if (idle_cnt_reg != CNT_MAX) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
